// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : voice_scheduler
//  Purpose  : Three-voice phase accumulator that time-shares one sine lookup
//             and mixes the returned samples into one saturated output.
//  Revision : 1.0
// ============================================================================
module voice_scheduler #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        generate_next,
    input  logic [2:0]  voice_en,
    input  logic [19:0] step_size_0,
    input  logic [19:0] step_size_1,
    input  logic [19:0] step_size_2,
    output logic        lookup_req,
    output logic [21:0] lookup_phase,
    input  logic        lookup_valid,
    input  logic [15:0] lookup_sample,
    output logic        sample_ready,
    output logic [15:0] sample,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0][21:0]   phase_q, phase_d;
    logic [2:0]         pend_q, pend_d;
    logic [1:0]         cur_q, cur_d;
    logic signed [17:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        sample_q, sample_d;
    logic               ready_q, ready_d;
    logic               terr_q, terr_d;

    logic [19:0]        step_sel;
    logic signed [17:0] half_acc;
    logic [15:0]        sat_val;
    logic               advance;

    function automatic logic [1:0] lowest_voice(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    always_comb begin
        case (cur_q)
            2'd0:    step_sel = step_size_0;
            2'd1:    step_sel = step_size_1;
            default: step_sel = step_size_2;
        endcase
    end

    assign half_acc = acc_q >>> 1;

    always_comb begin
        if (half_acc > 18'sd32767)
            sat_val = 16'h7FFF;
        else if (half_acc < -18'sd32768)
            sat_val = 16'h8000;
        else
            sat_val = half_acc[15:0];
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        pend_d       = pend_q;
        cur_d        = cur_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sample_d     = sample_q;
        ready_d      = 1'b0;
        terr_d       = terr_q;
        lookup_req   = 1'b0;
        lookup_phase = 22'd0;
        advance      = 1'b0;

        case (state_q)
            IDLE: begin
                if (generate_next) begin
                    acc_d = 18'sd0;
                    if (voice_en == 3'b000) begin
                        pend_d  = 3'b000;
                        state_d = DONE;
                    end else begin
                        cur_d   = lowest_voice(voice_en);
                        // Clearing the lowest set bit leaves the voices still to issue.
                        pend_d  = voice_en & (voice_en - 3'd1);
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                lookup_req     = 1'b1;
                lookup_phase   = phase_q[cur_q];
                phase_d[cur_q] = phase_q[cur_q] + {2'b00, step_sel};
                cnt_d          = '0;
                state_d        = WAIT;
            end
            WAIT: begin
                if (lookup_valid) begin
                    acc_d   = acc_q + $signed({{2{lookup_sample[15]}}, lookup_sample});
                    advance = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (advance) begin
                    if (pend_q != 3'b000) begin
                        cur_d   = lowest_voice(pend_q);
                        pend_d  = pend_q & (pend_q - 3'd1);
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                sample_d = sat_val;
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            pend_q   <= 3'b000;
            cur_q    <= 2'd0;
            acc_q    <= 18'sd0;
            cnt_q    <= '0;
            sample_q <= 16'd0;
            ready_q  <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            pend_q   <= pend_d;
            cur_q    <= cur_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            ready_q  <= ready_d;
            terr_q   <= terr_d;
        end
    end

    assign sample_ready = ready_q;
    assign sample       = sample_q;
    assign busy         = (state_q != IDLE);
    assign timeout_err  = terr_q;

endmodule
`default_nettype wire
